aha_axi_to_sif_write: RTL and testbench
=======================================

AHA_AXI_TO_SIF_WRITE -- requirements
Module: aha_axi_to_sif_write

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width (only default supported).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI/SIF address width.
REQ-003 SHALL have parameter DATA_W, default 64, AXI/SIF data width; strobe width DATA_W/8.
REQ-004 SHALL have port ACLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port ARESETn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports AWID in 4, AWADDR in 32, AWLEN in 8, AWSIZE in 3, AWBURST in 2, AWLOCK in 1, AWCACHE in 4, AWPROT in 3, AWVALID in 1, AWREADY out 1: AXI4 write-address channel; AWLOCK/AWCACHE/AWPROT ignored.
REQ-007 SHALL have ports WDATA in 64, WSTRB in 8, WLAST in 1, WVALID in 1, WREADY out 1: AXI4 write-data channel.
REQ-008 SHALL have ports BID out 4, BRESP out 2, BVALID out 1, BREADY in 1: AXI4 write-response channel.
REQ-009 SHALL have ports SIF_ADDR out 32, SIF_WE out 1, SIF_DATA out 64, SIF_STRB out 8: CGRA simple interface write port; accepts one write per cycle, no backpressure.

Function
REQ-010 SHALL implement FSM states IDLE, DATA, RESP.
REQ-011 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY capture AWID, AWADDR, AWLEN, AWSIZE, AWBURST, clear beat counter and error flag, go DATA.
REQ-012 DATA: AWREADY=0, WREADY=1; each WVALID&WREADY is one beat.
REQ-013 Per beat: SIF_WE=1, SIF_ADDR=current beat address, SIF_DATA=WDATA, SIF_STRB=WSTRB, all registered, visible exactly 1 cycle after the W handshake; SIF_WE=0 otherwise.
REQ-014 Beat count termination: beat with counter==AWLEN is last; go RESP next cycle; counter is 8-bit, max 256 beats.
REQ-015 WLAST mismatch (WLAST=1 before counter==AWLEN, or WLAST=0 on final beat) SHALL set error flag; burst still terminates on counter only.
REQ-016 Size: bytes=1<<AWSIZE; AWSIZE>3 SHALL be clamped to 3 and set error flag.
REQ-017 FIXED (2'b00): address constant all beats.
REQ-018 INCR (2'b01) and reserved 2'b11: next = (addr aligned down to bytes) + bytes; first beat uses AWADDR unaligned; wraps modulo 2^32.
REQ-019 WRAP (2'b10): wrap length L=(AWLEN+1)*bytes; next = lower + ((addr aligned + bytes - lower) mod L), lower = AWADDR aligned down to L; AWLEN not in {1,3,7,15} sets error flag, address behaves as INCR.
REQ-020 RESP: BVALID=1, BID=captured AWID, BRESP=2'b10 (SLVERR) if error flag else 2'b00 (OKAY); BVALID asserted cycle after final W handshake; held stable until BREADY; on BVALID&BREADY go IDLE.
REQ-021 AWREADY SHALL be 1 only in IDLE: at most one outstanding burst; W beats arriving in IDLE or RESP are stalled (WREADY=0), not dropped.
REQ-022 Back-to-back: IDLE re-entered the cycle after B handshake; next AW accepted that cycle; single-beat burst uses minimum 3 cycles plus BREADY wait.
REQ-023 SIF writes are issued even when error flag set (error reported only via BRESP).

Reset
REQ-024 ARESETn=0 at a rising edge SHALL force IDLE and AWREADY=1 (after reset), WREADY=0, BVALID=0, BID=0, BRESP=0, SIF_WE=0, SIF_ADDR=0, SIF_DATA=0, SIF_STRB=0.
REQ-025 Reset mid-burst SHALL abandon the burst without B response; any SIF write registered in the same edge SHALL be suppressed.
REQ-026 No asynchronous reset paths.

Structure
REQ-027 Shared package aha_axi_sif_pkg SHALL hold AXI burst encodings, RESP codes (OKAY/SLVERR), FSM state type, and size-clamp constant 3.
REQ-028 Address generation SHALL be sub-module aha_axi_to_sif_write_addr_gen (load on AW handshake, advance on W handshake, outputs current address).

Verification
REQ-029 INCR: AWADDR=0x1000, AWLEN=3, AWSIZE=3, WLAST on beat 3 -> SIF_WE 4 cycles at 0x1000/0x1008/0x1010/0x1018, BRESP=00, BID=AWID.
REQ-030 WRAP: AWADDR=0x2018, AWLEN=3, AWSIZE=3 -> SIF_ADDR 0x2018, 0x2000, 0x2008, 0x2010, BRESP=00.
REQ-031 FIXED with gaps: AWADDR=0x3004, AWLEN=2, AWSIZE=2, WVALID toggling -> three writes all at 0x3004, each 1 cycle after its handshake, WSTRB passed through.
REQ-032 Error: AWLEN=1 with WLAST=1 on beat 0 -> 2 SIF writes issued, BRESP=10; BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout.
REQ-033 Reset mid-burst: ARESETn low after beat 1 of AWLEN=7 -> no further SIF_WE, no BVALID, all outputs 0; new burst after reset completes with BRESP=00.

Source files
------------

// File: rtl/aha_axi_sif_pkg.sv
// Shared definitions for the AXI4-to-SIF write bridge.
//   - AXI burst type encodings and write-response codes
//   - write FSM state type
//   - transfer-size clamp (largest supported beat is 8 bytes, size code 3)
//   - helpers for size clamping and WRAP length legality
package aha_axi_sif_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_MAX    = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > SIZE_MAX) ? SIZE_MAX : size;
  endfunction

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/aha_axi_to_sif_write_addr_gen.sv
// Beat address generator for one AXI write burst.
// Ports:
//   ACLK, ARESETn : clock, synchronous active-low reset
//   load          : AW handshake; captures start address and burst shape
//   start_addr    : AWADDR
//   len           : AWLEN
//   size          : already-clamped AWSIZE (0..3)
//   burst         : AWBURST
//   advance       : W handshake; steps to the next beat address
//   addr          : address of the current (next to be written) beat
module aha_axi_to_sif_write_addr_gen
  import aha_axi_sif_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] bytes_q;
  logic [ADDR_W-1:0] wrap_mask_q;
  logic [1:0]        mode_q;

  logic [ADDR_W-1:0] bytes_ld;
  logic [ADDR_W-1:0] wrap_len_ld;
  logic [1:0]        mode_ld;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] next_addr;

  assign bytes_ld    = ADDR_W'(1) << size;
  assign wrap_len_ld = (ADDR_W'(len) + ADDR_W'(1)) << size;

  // Illegal WRAP lengths and the reserved encoding both fall back to INCR.
  always_comb begin
    mode_ld = BURST_INCR;
    if (burst == BURST_FIXED) begin
      mode_ld = BURST_FIXED;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      mode_ld = BURST_WRAP;
    end
  end

  // The first beat may be unaligned; every later beat is size-aligned.
  // For WRAP the wrap boundary is a power of two, so the upper bits of the
  // current address already hold the lower wrap bound.
  assign aligned   = addr_q & ~(bytes_q - ADDR_W'(1));
  assign incr_addr = aligned + bytes_q;

  always_comb begin
    next_addr = incr_addr;
    case (mode_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_q      <= '0;
      bytes_q     <= '0;
      wrap_mask_q <= '0;
      mode_q      <= BURST_FIXED;
    end else if (load) begin
      addr_q      <= start_addr;
      bytes_q     <= bytes_ld;
      wrap_mask_q <= wrap_len_ld - ADDR_W'(1);
      mode_q      <= mode_ld;
    end else if (advance) begin
      addr_q      <= next_addr;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/aha_axi_to_sif_write.sv
// AXI4 write slave that turns each accepted write beat into a single-cycle
// write on the CGRA simple interface (SIF). One burst outstanding at a time.
// Ports:
//   ACLK, ARESETn          : clock, synchronous active-low reset
//   AW* (ID/ADDR/LEN/SIZE/BURST/LOCK/CACHE/PROT/VALID/READY) : write address
//                            channel; LOCK/CACHE/PROT are accepted and ignored
//   W*  (DATA/STRB/LAST/VALID/READY) : write data channel
//   B*  (ID/RESP/VALID/READY)        : write response channel
//   SIF_ADDR/WE/DATA/STRB  : registered SIF write port, one write per cycle
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both 1. AWREADY is 1 only in IDLE, WREADY only in DATA, BVALID only in
// RESP; all three come straight from the registered state, and BID/BRESP
// stay stable while BVALID waits for BREADY.
// The FSM state is held in state_q for observation.
module aha_axi_to_sif_write
  import aha_axi_sif_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_W-1:0]       AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [ADDR_W-1:0]     SIF_ADDR,
  output logic                  SIF_WE,
  output logic [DATA_W-1:0]     SIF_DATA,
  output logic [DATA_W/8-1:0]   SIF_STRB
);

  wr_state_e         state_q;
  wr_state_e         state_d;

  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              err_q;

  logic              aw_hs;
  logic              w_hs;
  logic              beat_last;
  logic [2:0]        size_c;
  logic              size_err;
  logic              wrap_err;
  logic [ADDR_W-1:0] cur_addr;
  logic              unused_sideband;

  assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT};

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign beat_last = (cnt_q == len_q);
  assign size_c    = clamp_size(AWSIZE);
  assign size_err  = (AWSIZE > SIZE_MAX);
  assign wrap_err  = (AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN);

  aha_axi_to_sif_write_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .load       (aw_hs),
    .start_addr (AWADDR),
    .len        (AWLEN),
    .size       (size_c),
    .burst      (AWBURST),
    .advance    (w_hs),
    .addr       (cur_addr)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    case (state_q)
      ST_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) state_d = ST_DATA;
      end
      ST_DATA: begin
        WREADY = 1'b1;
        // The beat counter alone ends the burst; WLAST only feeds the error flag.
        if (WVALID && beat_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        BVALID = 1'b1;
        BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BID = id_q;

  // Reset shares the edge with the SIF register, so a beat accepted on the
  // same edge as reset never reaches the SIF port.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      SIF_WE   <= 1'b0;
      SIF_ADDR <= '0;
      SIF_DATA <= '0;
      SIF_STRB <= '0;
    end else begin
      SIF_WE <= w_hs;
      if (w_hs) begin
        SIF_ADDR <= cur_addr;
        SIF_DATA <= WDATA;
        SIF_STRB <= WSTRB;
      end
      if (aw_hs) begin
        id_q  <= AWID;
        len_q <= AWLEN;
        cnt_q <= '0;
        err_q <= size_err || wrap_err;
      end else if (w_hs) begin
        cnt_q <= cnt_q + 8'd1;
        if (WLAST != beat_last) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aha_axi_to_sif_write.sv
module tb_aha_axi_to_sif_write;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] SIF_ADDR;
  logic        SIF_WE;
  logic [63:0] SIF_DATA;
  logic [7:0]  SIF_STRB;

  aha_axi_to_sif_write dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWLOCK   (AWLOCK),
    .AWCACHE  (AWCACHE),
    .AWPROT   (AWPROT),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .SIF_ADDR (SIF_ADDR),
    .SIF_WE   (SIF_WE),
    .SIF_DATA (SIF_DATA),
    .SIF_STRB (SIF_STRB)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_bytes(input logic [2:0] size);
    return 32'd1 << ((size > 3'd3) ? 3'd3 : size);
  endfunction

  function automatic logic m_wrap_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Closed-form address of beat i of a burst.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
    logic [31:0] bytes;
    logic [31:0] aligned;
    logic [31:0] wlen;
    logic [31:0] lower;
    logic [31:0] step;
    bytes = m_bytes(size);
    if (burst == 2'b00 || i == 0) return start;
    aligned = (start / bytes) * bytes;
    step = 32'(i) * bytes;
    if (burst == 2'b10 && m_wrap_legal(len)) begin
      wlen  = (32'(len) + 32'd1) * bytes;
      lower = (start / wlen) * wlen;
      return lower + ((aligned - lower + step) % wlen);
    end
    return aligned + step;
  endfunction

  function automatic logic model_cfg_err(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    return (size > 3'd3) || (burst == 2'b10 && !m_wrap_legal(len));
  endfunction

  // ---------------- scoreboard: SIF write port ----------------
  logic [103:0] exp_q[$];
  logic [103:0] mon_e;
  logic         mon_en = 1'b0;
  logic         hs_prev = 1'b0;

  // A SIF write is owed exactly one cycle after each W handshake unless a
  // reset edge intervenes.
  always @(negedge ACLK) begin
    if (mon_en) begin
      check("sif_we", SIF_WE, hs_prev);
      if (SIF_WE) begin
        if (exp_q.size() == 0) begin
          check("sif_unexpected_write", SIF_WE, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sif_addr", SIF_ADDR, mon_e[103:72]);
          check("sif_strb", SIF_STRB, mon_e[71:64]);
          check("sif_data", SIF_DATA, mon_e[63:0]);
        end
      end
    end
    hs_prev = WVALID && WREADY && ARESETn;
  end

  // ---------------- driver tasks ----------------
  task automatic do_beat(input logic [31:0] addr, input logic last_flag, output bit ok);
    WVALID = 1'b1;
    WDATA  = {$urandom, $urandom};
    WSTRB  = 8'($urandom_range(0, 255));
    WLAST  = last_flag;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge ACLK);
      if (WREADY) begin
        exp_q.push_back({addr, WSTRB, WDATA});
        ok = 1'b1;
      end
      @(posedge ACLK);
      #1;
      if (ok) break;
    end
    if (!ok) check("wready_wait", WREADY, 1'b1);
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic apply_mid_reset();
    ARESETn = 1'b0;
    @(negedge ACLK);
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("rst_awready", AWREADY, 1'b1);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_bid", BID, 4'h0);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_sif_we", SIF_WE, 1'b0);
    check("rst_sif_addr", SIF_ADDR, 32'h0);
    check("rst_sif_data", SIF_DATA, 64'h0);
    check("rst_sif_strb", SIF_STRB, 8'h0);
    check("rst_exp_drained", 64'(exp_q.size()), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check("post_rst_bvalid", BVALID, 1'b0);
      @(posedge ACLK);
      #1;
    end
  endtask

  // Runs one burst. err_beat flips WLAST on that beat (-1: none);
  // abort_after applies reset after that beat's handshake (-1: never).
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           input int gap_min, input int gap_max, input int err_beat,
                           input int bready_delay, input int abort_after);
    bit          ok;
    logic        exp_err;
    logic [1:0]  exp_resp;
    logic        lastf;
    int          gap;
    AWID    = id;
    AWADDR  = addr;
    AWLEN   = len;
    AWSIZE  = size;
    AWBURST = burst;
    AWLOCK  = 1'($urandom_range(0, 1));
    AWCACHE = 4'($urandom_range(0, 15));
    AWPROT  = 3'($urandom_range(0, 7));
    AWVALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge ACLK);
      if (t == 0) begin
        check("aw_ready_idle", AWREADY, 1'b1);
        check("b_idle_low", BVALID, 1'b0);
      end
      if (AWREADY) ok = 1'b1;
      @(posedge ACLK);
      #1;
      if (ok) break;
    end
    if (!ok) check("awready_wait", AWREADY, 1'b1);
    AWVALID = 1'b0;
    exp_err = model_cfg_err(len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      gap = $urandom_range(gap_min, gap_max);
      repeat (gap) begin
        @(negedge ACLK);
        check("data_awready_low", AWREADY, 1'b0);
        @(posedge ACLK);
        #1;
      end
      lastf = (i == int'(len)) ^ (i == err_beat);
      if (lastf != (i == int'(len))) exp_err = 1'b1;
      do_beat(model_addr(addr, len, size, burst, i), lastf, ok);
      if (i == abort_after) begin
        apply_mid_reset();
        return;
      end
    end
    exp_resp = exp_err ? 2'b10 : 2'b00;
    @(negedge ACLK);
    check("bvalid_after_last", BVALID, 1'b1);
    check("bid", BID, id);
    check("bresp", BRESP, exp_resp);
    check("resp_awready_low", AWREADY, 1'b0);
    check("resp_wready_low", WREADY, 1'b0);
    repeat (bready_delay) begin
      @(posedge ACLK);
      #1;
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 1'b1);
      check("bid_hold", BID, id);
      check("bresp_hold", BRESP, exp_resp);
      check("hold_awready_low", AWREADY, 1'b0);
    end
    @(posedge ACLK);
    #1;
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bvalid_at_bready", BVALID, 1'b1);
    @(posedge ACLK);
    #1;
    BREADY = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWLOCK = 1'b0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("reset_awready", AWREADY, 1'b1);
    check("reset_wready", WREADY, 1'b0);
    check("reset_bvalid", BVALID, 1'b0);
    check("reset_bid", BID, 4'h0);
    check("reset_bresp", BRESP, 2'b00);
    check("reset_sif_we", SIF_WE, 1'b0);
    check("reset_sif_addr", SIF_ADDR, 32'h0);
    check("reset_sif_data", SIF_DATA, 64'h0);
    check("reset_sif_strb", SIF_STRB, 8'h0);
    mon_en = 1'b1;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;

    // W presented while idle must be stalled, not consumed.
    WVALID = 1'b1;
    WDATA  = 64'hdead_beef_0000_0001;
    WSTRB  = 8'hff;
    repeat (2) begin
      @(negedge ACLK);
      check("wready_idle_stall", WREADY, 1'b0);
      @(posedge ACLK);
      #1;
    end
    WVALID = 1'b0;

    // INCR 4 x 8 bytes, correct WLAST.
    run_burst(32'h0000_1000, 8'd3, 3'd3, 2'b01, 4'h5, 0, 0, -1, 0, -1);
    // WRAP 4 x 8 bytes starting mid-window.
    run_burst(32'h0000_2018, 8'd3, 3'd3, 2'b10, 4'ha, 0, 0, -1, 1, -1);
    // FIXED with WVALID gaps.
    run_burst(32'h0000_3004, 8'd2, 3'd2, 2'b00, 4'h3, 1, 2, -1, 0, -1);
    // Early WLAST on beat 0 of a 2-beat burst, BREADY held off 5 cycles.
    run_burst(32'h0000_4000, 8'd1, 3'd3, 2'b01, 4'h7, 0, 0, 0, 5, -1);
    // Reset after beat 1 of an 8-beat burst, then a clean burst.
    run_burst(32'h0000_5000, 8'd7, 3'd3, 2'b01, 4'h2, 0, 1, -1, 0, 1);
    run_burst(32'h0000_6000, 8'd0, 3'd2, 2'b01, 4'h9, 0, 0, -1, 0, -1);
    // Oversized AWSIZE, illegal WRAP length, reserved burst type.
    run_burst(32'h0000_7003, 8'd2, 3'd6, 2'b01, 4'h1, 0, 0, -1, 0, -1);
    run_burst(32'h0000_8010, 8'd2, 3'd2, 2'b10, 4'h4, 0, 0, -1, 0, -1);
    run_burst(32'h0000_9001, 8'd3, 3'd1, 2'b11, 4'h6, 0, 0, -1, 0, -1);
    // Missing WLAST on the final beat.
    run_burst(32'h0000_a000, 8'd2, 3'd3, 2'b01, 4'hb, 0, 0, 2, 0, -1);
    // 256-beat burst crossing the top of the address space.
    run_burst(32'hffff_ff80, 8'd255, 3'd0, 2'b01, 4'hc, 0, 0, -1, 0, -1);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] r_len;
      int         r_err;
      r_len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 15));
      r_err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r_len) + 1)) : -1;
      run_burst($urandom, r_len, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 0, 2, r_err, int'($urandom_range(0, 3)), -1);
    end

    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("final_exp_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
